decimal_to_flp: RTL

//  Multi-cycle converter from a sign + integer part + binary-fraction part to

---
 rtl/decimal_to_flp.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/decimal_to_flp.sv
// -----------------------------------------------------------------------------
// decimal_to_flp
//   Multi-cycle converter from sign + integer part (nguyen) + binary fraction
//   (thapphan) to IEEE-754 single precision. The accepted operand is loaded
//   into a work register W = {nguyen, thapphan}. W is normalised by left
//   shifts until its MSB is set. The result is then rounded to nearest-even
//   and packed. There are no denormal, infinity or NaN outputs.
//
//   Optional feature macro: FAST_NORM_EN
//     defined   : a leading-zero count taken at accept lets NORM do a single
//                 barrel shift (nonzero latency fixed at 2 cycles)
//     undefined : one-bit-per-cycle serial shifter (latency N+2 cycles)
//   Both builds produce bit-identical results.
//
// Ports
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous active-high reset (aborts conversion)
//   start     in   1       request, accepted only while busy=0
//   sign      in   1       sign of the result
//   nguyen    in   INT_W   integer magnitude
//   thapphan  in   FRAC_W  fraction magnitude, MSB weighs 2^-1
//   busy      out  1       high from the accept edge until done
//   done      out  1       one-cycle completion pulse
//   A         out  32      {sign, exp[7:0], mant[22:0]}, held until next done
// -----------------------------------------------------------------------------
module decimal_to_flp #(
    parameter int INT_W  = 24,
    parameter int FRAC_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign,
    input  logic [INT_W-1:0]  nguyen,
    input  logic [FRAC_W-1:0] thapphan,
    output logic              busy,
    output logic              done,
    output logic [31:0]       A
);

    localparam int W_W   = INT_W + FRAC_W;
    localparam int W_MSB = W_W - 1;
    localparam int N_W   = $clog2(W_W);
    localparam logic [8:0] E_INIT = 9'(127 + INT_W - 1);
    // Bits below the guard bit; empty when W is exactly 25 bits wide.
    localparam logic [W_W-1:0] STICKY_MASK = {W_W{1'b1}} >> 25;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND
    } state_t;

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic [31:0]      a_q, a_d;
    logic [W_W-1:0]   w_q, w_d;
    logic [8:0]       e_q, e_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;
`ifdef FAST_NORM_EN
    logic [N_W-1:0]   n_q, n_d;
`endif

    // Round-to-nearest-even on a normalised W (MSB is the hidden one).
    function automatic logic [31:0] round_pack(input logic s,
                                               input logic [W_W-1:0] w,
                                               input logic [8:0] e);
        logic        g, st, lsb, up;
        logic [23:0] mant_r;
        logic [8:0]  exp_r;
        g      = w[W_MSB-24];
        st     = |(w & STICKY_MASK);
        lsb    = w[W_MSB-23];
        up     = g & (st | lsb);
        mant_r = {1'b0, w[W_MSB-1 -: 23]} + 24'(up);
        // A carry out of the 23-bit mantissa leaves mant_r[22:0] all zero.
        exp_r  = e + 9'(mant_r[23]);
        return {s, exp_r[7:0], mant_r[22:0]};
    endfunction

`ifdef FAST_NORM_EN
    // Leading-zero count; the value for an all-zero word is never used.
    function automatic logic [N_W-1:0] lzc(input logic [W_W-1:0] w);
        logic [N_W-1:0] n;
        n = '0;
        for (int i = 0; i < W_W; i++) begin
            if (w[i]) n = N_W'(W_MSB - i);
        end
        return n;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        a_d     = a_q;
        w_d     = w_q;
        e_d     = e_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
`ifdef FAST_NORM_EN
        n_d     = n_q;
`endif
        case (state_q)
            // Accept: sample operand, zero operands skip normalisation.
            S_IDLE: begin
                if (start) begin
                    w_d    = {nguyen, thapphan};
                    e_d    = E_INIT;
                    sign_d = sign;
                    zero_d = ~|{nguyen, thapphan};
`ifdef FAST_NORM_EN
                    n_d    = lzc({nguyen, thapphan});
`endif
                    state_d = zero_d ? S_ROUND : S_NORM;
                end
            end
            // Normalise: bring the leading one to the MSB of W.
            S_NORM: begin
`ifdef FAST_NORM_EN
                w_d     = w_q << n_q;
                e_d     = e_q - 9'(n_q);
                state_d = S_ROUND;
`else
                if (w_q[W_MSB]) begin
                    state_d = S_ROUND;
                end else begin
                    w_d = w_q << 1;
                    e_d = e_q - 9'd1;
                end
`endif
            end
            // Round and pack; done is seen the cycle after, back in IDLE.
            S_ROUND: begin
                a_d     = zero_q ? {sign_q, 31'b0} : round_pack(sign_q, w_q, e_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            a_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            a_q     <= a_d;
        end
    end

    // Work registers are only meaningful once loaded at accept.
    always_ff @(posedge clk) begin
        w_q    <= w_d;
        e_q    <= e_d;
        sign_q <= sign_d;
        zero_q <= zero_d;
`ifdef FAST_NORM_EN
        n_q    <= n_d;
`endif
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign A    = a_q;

endmodule
